// File: rtl/pc_fetch_unit.sv
// PC / instruction-fetch stage: drives the ROM address and holds the returned word in an IF/ID register for decode.
// Latency: one cycle from PC to IF/ID. Backpressure: a stall (if_valid & !if_ready) freezes both the PC and IF/ID.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    output logic [30:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        illop,
    input  logic        irq,
    output logic        exc_taken,
    output logic        exc_cause,
    output logic [31:0] exc_epc
);

    logic [31:0] pc, pc_d, pc_next_seq, redir_pc;
    logic [31:0] if_instr_d, if_pc_d, exc_epc_d;
    logic        if_valid_d, exc_taken_d, exc_cause_d;
    logic        irq_pending;
    logic        consume, take_exc, take_redir, take_irq, do_load;

    assign rom_addr    = pc[30:0];
    assign pc_next_seq = {pc[31], pc[30:0] + 31'd4};
    assign if_pc_plus4 = {if_pc[31], if_pc[30:0] + 31'd4};

    // Kernel bit may only be kept or cleared by a redirect, never set from user mode.
    assign redir_pc = {redir_target[31] & if_pc[31], redir_target[30:0]};

    assign consume    = if_valid & if_ready;
    assign take_exc   = illop & if_valid;
    assign take_redir = !take_exc & redir_valid & consume;
    assign take_irq   = !take_exc & !take_redir & irq_pending & !if_pc[31] & consume;
    assign do_load    = !take_exc & !take_redir & !take_irq & (!if_valid | if_ready);

    always_comb begin
        pc_d        = pc;
        if_valid_d  = if_valid;
        if_instr_d  = if_instr;
        if_pc_d     = if_pc;
        exc_taken_d = 1'b0;
        exc_cause_d = exc_cause;
        exc_epc_d   = exc_epc;
        if (take_exc) begin
            pc_d        = EXC_VECTOR;
            if_valid_d  = 1'b0;
            exc_taken_d = 1'b1;
            exc_cause_d = 1'b1;
            exc_epc_d   = if_pc_plus4;
        end else if (take_redir) begin
            pc_d       = redir_pc;
            if_valid_d = 1'b0;
        end else if (take_irq) begin
            // The squashed instruction is re-fetched on return, so EPC points at it.
            pc_d        = IRQ_VECTOR;
            if_valid_d  = 1'b0;
            exc_taken_d = 1'b1;
            exc_cause_d = 1'b0;
            exc_epc_d   = if_pc;
        end else if (do_load) begin
            pc_d       = pc_next_seq;
            if_valid_d = 1'b1;
            if_instr_d = rom_data;
            if_pc_d    = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_VECTOR;
            if_valid    <= 1'b0;
            if_instr    <= 32'h0;
            if_pc       <= 32'h0;
            irq_pending <= 1'b0;
            exc_taken   <= 1'b0;
            exc_cause   <= 1'b0;
            exc_epc     <= 32'h0;
        end else begin
            pc          <= pc_d;
            if_valid    <= if_valid_d;
            if_instr    <= if_instr_d;
            if_pc       <= if_pc_d;
            irq_pending <= irq;
            exc_taken   <= exc_taken_d;
            exc_cause   <= exc_cause_d;
            exc_epc     <= exc_epc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus a randomized run against a cycle reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [30:0] rom_addr;
    logic [31:0] rom_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        illop;
    logic        irq;
    logic        exc_taken;
    logic        exc_cause;
    logic [31:0] exc_epc;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_ipc, m_epc;
    logic        m_v, m_irqp, m_exc, m_cause;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .redir_valid(redir_valid), .redir_target(redir_target),
        .illop(illop), .irq(irq), .exc_taken(exc_taken), .exc_cause(exc_cause), .exc_epc(exc_epc)
    );

    function automatic logic [31:0] rom_word(input logic [30:0] a);
        case (a)
            31'd0:   rom_word = 32'h3C08_4000;
            31'd4:   rom_word = 32'h8D09_0020;
            31'd8:   rom_word = 32'h0000_0000;
            default: rom_word = {a, 1'b1} ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    assign rom_data = rom_word(rom_addr);

    // Advance one clock; the model applies the fetch rules to the inputs present before the edge.
    task automatic tick();
        if (reset) begin
            m_pc = 32'h8000_0000; m_v = 1'b0; m_instr = 32'h0; m_ipc = 32'h0;
            m_irqp = 1'b0; m_exc = 1'b0; m_cause = 1'b0; m_epc = 32'h0;
        end else begin
            m_exc = 1'b0;
            if (m_v && illop) begin
                m_exc = 1'b1; m_cause = 1'b1;
                m_epc = {m_ipc[31], m_ipc[30:0] + 31'd4};
                m_pc = 32'h8000_0008; m_v = 1'b0;
            end else if (m_v && if_ready && redir_valid) begin
                m_pc = {redir_target[31] && m_ipc[31], redir_target[30:0]};
                m_v = 1'b0;
            end else if (m_v && if_ready && m_irqp && !m_ipc[31]) begin
                m_exc = 1'b1; m_cause = 1'b0; m_epc = m_ipc;
                m_pc = 32'h8000_0004; m_v = 1'b0;
            end else if (!m_v || if_ready) begin
                m_instr = rom_word(m_pc[30:0]);
                m_ipc = m_pc;
                m_v = 1'b1;
                m_pc = {m_pc[31], m_pc[30:0] + 31'd4};
            end
            m_irqp = irq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; if_ready = 1'b0; redir_valid = 1'b0; redir_target = 32'h0;
        illop = 1'b0; irq = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({if_valid, exc_taken, exc_cause} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags got v=%b exc=%b cause=%b want 000", if_valid, exc_taken, exc_cause);
        end
        n_vec++;
        if (rom_addr !== 31'h0) begin
            n_err++; $display("FAIL reset_rom_addr got %h want 0", rom_addr);
        end
        n_vec++;
        if ({if_pc, if_instr, exc_epc} !== 96'h0) begin
            n_err++; $display("FAIL reset_regs got pc=%h instr=%h epc=%h want 0", if_pc, if_instr, exc_epc);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h3C08_4000; exp_w[1] = 32'h8D09_0020; exp_w[2] = 32'h0000_0000;
        do_reset();
        if_ready = 1'b1;
        n_vec++;
        if (rom_addr !== 31'h0) begin
            n_err++; $display("FAIL fetch_first_addr got %h want 0", rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h8000_0000 + 32'(i * 4), exp_w[i]}) begin
                n_err++; $display("FAIL fetch_seq%0d got v=%b pc=%h instr=%h want pc=%h instr=%h",
                                  i, if_valid, if_pc, if_instr, 32'h8000_0000 + 32'(i * 4), exp_w[i]);
            end
            n_vec++;
            if (rom_addr !== 31'(i * 4 + 4)) begin
                n_err++; $display("FAIL fetch_addr%0d got %h want %h", i, rom_addr, 31'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        if_ready = 1'b1;
        tick();
        tick();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({if_valid, if_pc, if_instr, rom_addr} !== {1'b1, 32'h8000_0004, 32'h8D09_0020, 31'h8}) begin
                n_err++; $display("FAIL stall%0d got v=%b pc=%h instr=%h addr=%h want pc=80000004 addr=8",
                                  i, if_valid, if_pc, if_instr, rom_addr);
            end
        end
        if_ready = 1'b1;
        tick();
        n_vec++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h8000_0008, 32'h0}) begin
            n_err++; $display("FAIL stall_release got v=%b pc=%h instr=%h want pc=80000008", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        if_ready = 1'b1;
        tick();
        redir_valid = 1'b1; redir_target = 32'h0000_0040;
        tick();
        redir_valid = 1'b0;
        n_vec++;
        if ({if_valid, rom_addr} !== {1'b0, 31'h40}) begin
            n_err++; $display("FAIL redir_bubble got v=%b addr=%h want v=0 addr=40", if_valid, rom_addr);
        end
        tick();
        n_vec++;
        if ({if_valid, if_pc} !== {1'b1, 32'h0000_0040}) begin
            n_err++; $display("FAIL redir_k2u got v=%b pc=%h want pc=00000040", if_valid, if_pc);
        end
        redir_valid = 1'b1; redir_target = 32'h8000_0010;
        tick();
        redir_valid = 1'b0;
        tick();
        n_vec++;
        if ({if_valid, if_pc} !== {1'b1, 32'h0000_0010}) begin
            n_err++; $display("FAIL redir_user_guard got v=%b pc=%h want pc=00000010", if_valid, if_pc);
        end
    endtask

    task automatic test_irq();
        do_reset();
        if_ready = 1'b1;
        tick();
        redir_valid = 1'b1; redir_target = 32'h0000_0040;
        tick();
        redir_valid = 1'b0;
        tick();
        tick();
        irq = 1'b1;
        tick();
        n_vec++;
        if ({if_valid, if_pc, exc_taken} !== {1'b1, 32'h0000_0048, 1'b0}) begin
            n_err++; $display("FAIL irq_pre got v=%b pc=%h exc=%b want pc=00000048 exc=0", if_valid, if_pc, exc_taken);
        end
        tick();
        n_vec++;
        if ({exc_taken, exc_cause, exc_epc, if_valid} !== {1'b1, 1'b0, 32'h0000_0048, 1'b0}) begin
            n_err++; $display("FAIL irq_take got exc=%b cause=%b epc=%h v=%b want 1 0 00000048 0",
                              exc_taken, exc_cause, exc_epc, if_valid);
        end
        tick();
        n_vec++;
        if ({if_valid, if_pc, exc_taken} !== {1'b1, 32'h8000_0004, 1'b0}) begin
            n_err++; $display("FAIL irq_vector got v=%b pc=%h exc=%b want pc=80000004", if_valid, if_pc, exc_taken);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (exc_taken !== 1'b0) begin
                n_err++; $display("FAIL irq_kernel_mask%0d got exc=%b want 0", i, exc_taken);
            end
        end
        irq = 1'b0;
    endtask

    task automatic test_illop();
        do_reset();
        if_ready = 1'b1;
        tick();
        redir_valid = 1'b1; redir_target = 32'h0000_005C;
        tick();
        redir_valid = 1'b0;
        tick();
        if_ready = 1'b0; illop = 1'b1;
        tick();
        illop = 1'b0;
        n_vec++;
        if ({exc_taken, exc_cause, exc_epc, if_valid} !== {1'b1, 1'b1, 32'h0000_0060, 1'b0}) begin
            n_err++; $display("FAIL illop_take got exc=%b cause=%b epc=%h v=%b want 1 1 00000060 0",
                              exc_taken, exc_cause, exc_epc, if_valid);
        end
        if_ready = 1'b1;
        tick();
        n_vec++;
        if ({if_valid, if_pc, exc_taken} !== {1'b1, 32'h8000_0008, 1'b0}) begin
            n_err++; $display("FAIL illop_vector got v=%b pc=%h exc=%b want pc=80000008", if_valid, if_pc, exc_taken);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        if_ready = 1'b1;
        tick();
        redir_valid = 1'b1; redir_target = 32'h0000_0100;
        tick();
        redir_valid = 1'b0;
        tick();
        if_ready = 1'b0; irq = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        n_vec++;
        if ({if_valid, exc_taken, rom_addr} !== {1'b0, 1'b0, 31'h0}) begin
            n_err++; $display("FAIL rst_stall got v=%b exc=%b addr=%h want 0 0 0", if_valid, exc_taken, rom_addr);
        end
        reset = 1'b0; if_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({if_valid, if_pc, exc_taken} !== {1'b1, 32'h8000_0000 + 32'(i * 4), 1'b0}) begin
                n_err++; $display("FAIL rst_stall_first%0d got v=%b pc=%h exc=%b", i, if_valid, if_pc, exc_taken);
            end
        end
        irq = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_p4;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 249) == 0);
            if_ready     = ($urandom_range(0, 3) != 0);
            redir_valid  = ($urandom_range(0, 6) == 0);
            redir_target = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 23'h0, 6'($urandom), 2'b00};
            illop        = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) irq = ~irq;
            tick();
            exp_p4 = {m_ipc[31], m_ipc[30:0] + 31'd4};
            n_vec++;
            if ({if_valid, if_pc, if_instr, if_pc_plus4, rom_addr, exc_taken} !==
                {m_v, m_ipc, m_instr, exp_p4, m_pc[30:0], m_exc}) begin
                n_err++; $display("FAIL rand%0d got v=%b pc=%h instr=%h p4=%h addr=%h exc=%b want v=%b pc=%h instr=%h p4=%h addr=%h exc=%b",
                                  i, if_valid, if_pc, if_instr, if_pc_plus4, rom_addr, exc_taken,
                                  m_v, m_ipc, m_instr, exp_p4, m_pc[30:0], m_exc);
            end
            if (m_exc) begin
                n_vec++;
                if ({exc_cause, exc_epc} !== {m_cause, m_epc}) begin
                    n_err++; $display("FAIL rand_exc%0d got cause=%b epc=%h want cause=%b epc=%h",
                                      i, exc_cause, exc_epc, m_cause, m_epc);
                end
            end
        end
        reset = 1'b0; redir_valid = 1'b0; illop = 1'b0; irq = 1'b0;
    endtask

    initial begin
        reset = 1'b1; if_ready = 1'b0; redir_valid = 1'b0; redir_target = 32'h0;
        illop = 1'b0; irq = 1'b0;
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect();
        test_irq();
        test_illop();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage that directly feeds the instruction ROM. It drives the 31-bit byte address and captures the returned word into an IF/ID register.
- Presents the captured instruction to decode over a valid/ready handshake.
- Handles next-PC selection for sequential flow, branch/jump/jr redirects, timer interrupts and illegal-opcode exceptions.
- PC[31] is the kernel/supervisor bit: it is never sent to the ROM and is protected against user-mode setting.

Parameters:
RESET_VECTOR  32'h8000_0000  PC value loaded on reset (kernel mode)
IRQ_VECTOR  32'h8000_0004  interrupt handler entry
EXC_VECTOR  32'h8000_0008  illegal-opcode handler entry

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high
rom_addr  out  31  PC[30:0], combinational from PC register
rom_data  in  32  ROM word for rom_addr, valid same cycle (combinational ROM)
if_valid  out  1  IF/ID register holds an instruction
if_ready  in  1  decode consumes IF/ID contents this cycle
if_instr  out  32  captured instruction
if_pc  out  32  full PC (incl. bit 31) of if_instr
if_pc_plus4  out  32  {if_pc[31], if_pc[30:0]+4}
redir_valid  in  1  decode/execute redirect (branch taken, j, jal, jr), qualified by if_valid & if_ready
redir_target  in  32  redirect target address
illop  in  1  decode flags if_instr as illegal, qualified by if_valid
irq  in  1  level interrupt request from timer peripheral
exc_taken  out  1  one-cycle pulse: interrupt or exception entered
exc_cause  out  1  0 = interrupt, 1 = illegal opcode (valid with exc_taken)
exc_epc  out  32  value decode writes into $k0 (valid with exc_taken)

Behaviour:
- Reset (any cycle, overrides everything):
  - pc <= RESET_VECTOR; if_valid <= 0; if_instr/if_pc <= 0.
  - irq_pending <= 0; exc_taken <= 0; exc_cause <= 0; exc_epc <= 0.
- Sequential increment: pc_next_seq = {pc[31], pc[30:0]+4}. Bit 31 is never changed by the carry; 31-bit wrap is allowed silently.
- irq_pending <= irq every cycle (registered sample, 1-cycle latency).
- Per-cycle priority, highest first:
  1. illop & if_valid:
     - pc <= EXC_VECTOR; if_valid <= 0 (flush).
     - exc_taken <= 1, exc_cause <= 1, exc_epc <= if_pc_plus4 (faulting instruction skipped).
     - if_ready is ignored this cycle.
  2. redir_valid & if_valid & if_ready:
     - pc <= target'; if_valid <= 0. The word at the old pc is discarded; there are no architectural delay slots.
     - target'[30:0] = redir_target[30:0].
     - target'[31] = redir_target[31] & if_pc[31]. Kernel may drop to user (jr $k0 returns); user cannot enter kernel.
  3. irq_pending & !if_pc[31] & if_valid & if_ready:
     - Instruction in IF/ID is squashed (not executed); pc <= IRQ_VECTOR; if_valid <= 0.
     - exc_taken <= 1, exc_cause <= 0, exc_epc <= if_pc, so the handler's return re-fetches the squashed instruction.
  4. !if_valid | if_ready (load):
     - if_instr <= rom_data; if_pc <= pc; if_valid <= 1; pc <= pc_next_seq.
  5. Otherwise (stall: if_valid & !if_ready): pc and the IF/ID register hold; rom_addr stays stable.
- Interrupt masking:
  - Interrupts are never taken while if_pc[31]=1 (kernel).
  - An interrupt coinciding with a redirect is deferred to the first boundary after it, provided it is still asserted and in user mode.
- exc_taken is low in every cycle not listed in cases 1 and 3.
- Fetch latency: reset released at cycle 0 → rom_addr = 0 → if_valid = 1 with if_pc = 0x8000_0000 at cycle 1.
- Throughput: one instruction per cycle while if_ready = 1.
- When if_valid = 0, if_instr/if_pc hold their stale values; decode must ignore them.

Test Plan:
- Reset, then hold if_ready = 1 with ROM words 0x3C084000, 0x8D090020, 0x00000000:
  - rom_addr = 0, 4, 8 on consecutive cycles.
  - if_pc = 0x80000000, 0x80000004, 0x80000008; if_instr matches each word.
- Backpressure:
  - Drop if_ready for 3 cycles at if_pc = 0x80000004 → if_instr, if_pc and rom_addr stay frozen.
  - Release → 0x80000008 follows with no skip or duplicate.
- Redirect:
  - redir_valid with redir_target = 0x00000040 from kernel → next if_pc = 0x00000040 (user); exactly one bubble (if_valid = 0 for 1 cycle).
  - From user, redir_target = 0x80000010 → if_pc = 0x00000010.
- Interrupt:
  - irq = 1 while executing user code at if_pc = 0x00000048 → exc_taken = 1, exc_cause = 0, exc_epc = 0x00000048.
  - Next if_pc = 0x80000004.
  - irq held while in kernel → no second exc_taken.
- Illegal opcode: illop with if_pc = 0x0000005C (asserted while if_ready = 0) → exc_cause = 1, exc_epc = 0x00000060, next if_pc = 0x80000008.
- Reset mid-stall (if_valid = 1, if_ready = 0, irq = 1) → next cycle if_valid = 0, exc_taken = 0, pc = 0x80000000; no interrupt is taken at the first instruction.
